// File: rtl/sg_dma_rd_arb.sv
// sg_dma_rd_arb: NUM_CH channel readers share one AVMM burst read master; returning beats are routed in issue order.
// Define SG_DMA_RD_ARB_PRIO_EN to give ch0 strict priority over a round-robin among the remaining channels.
module sg_dma_rd_arb #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int BCNT_W      = 11,
  parameter int OUTST_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_rd_req_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_rd_addr_i,
  input  logic [NUM_CH*BCNT_W-1:0]     ch_rd_bcount_i,
  output logic [NUM_CH-1:0]            ch_rd_gnt_o,
  output logic [DATA_W-1:0]            ch_rd_data_o,
  output logic [NUM_CH-1:0]            ch_rd_data_valid_o,
  output logic [ADDR_W-1:0]            rd_master_addr_o,
  output logic [BCNT_W-1:0]            rd_master_bcount_o,
  output logic                         rd_master_rd_o,
  input  logic                         rd_master_wait_req_i,
  input  logic                         rd_master_data_valid_i,
  input  logic [DATA_W-1:0]            rd_master_data_i,
  output logic [$clog2(OUTST_DEPTH):0] outst_cnt_o,
  output logic                         err_o
);
  localparam int IDW = $clog2(NUM_CH);
  localparam int PW  = $clog2(OUTST_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, GNT} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, id, win, id_nx;
  logic found, sel, push, pop, beat, empty, full;
  logic [BCNT_W-1:0] win_bc, left, rem;
  logic [PW:0] wp, rp;
  logic [IDW-1:0] f_id [OUTST_DEPTH];
  logic [BCNT_W-1:0] f_bc [OUTST_DEPTH];

  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % NUM_CH);
  endfunction

  // first requester at or after ptr; ptr already holds last_granted+1
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
`ifdef SG_DMA_RD_ARB_PRIO_EN
      if (!found && ch_rd_req_i[wrap(int'(ptr) + i)] && wrap(int'(ptr) + i) != '0) begin
`else
      if (!found && ch_rd_req_i[wrap(int'(ptr) + i)]) begin
`endif
        win = wrap(int'(ptr) + i);
        found = 1'b1;
      end
`ifdef SG_DMA_RD_ARB_PRIO_EN
    if (ch_rd_req_i[0]) begin
      win = '0;
      found = 1'b1;
    end
`endif
  end

  assign win_bc      = ch_rd_bcount_i[win*BCNT_W +: BCNT_W];
  assign id_nx       = (id == IDW'(NUM_CH - 1)) ? '0 : id + 1'b1;
  assign sel         = state == IDLE && found && !full;
  assign push        = state == ISSUE && !rd_master_wait_req_i;
  assign beat        = rd_master_data_valid_i;
  assign outst_cnt_o = wp - rp;
  assign empty       = wp == rp;
  assign full        = outst_cnt_o == (PW+1)'(OUTST_DEPTH);
  // left==0 means the head burst has not delivered a beat yet
  assign rem         = left == '0 ? f_bc[rp[PW-1:0]] : left;
  assign pop         = beat && !empty && rem == BCNT_W'(1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = state == IDLE  ? (sel ? (win_bc == '0 ? GNT : ISSUE) : IDLE) :
               state == ISSUE ? (rd_master_wait_req_i ? ISSUE : GNT) : IDLE;

  always_comb begin
    rd_master_rd_o = state == ISSUE;
    ch_rd_gnt_o    = state == GNT ? NUM_CH'(1) << id : '0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr                <= '0;
      id                 <= '0;
      rd_master_addr_o   <= '0;
      rd_master_bcount_o <= '0;
      wp                 <= '0;
      rp                 <= '0;
      left               <= '0;
      ch_rd_data_o       <= '0;
      ch_rd_data_valid_o <= '0;
      err_o              <= 1'b0;
    end else begin
      if (sel) begin
        id                 <= win;
        rd_master_addr_o   <= ch_rd_addr_i[win*ADDR_W +: ADDR_W];
        rd_master_bcount_o <= win_bc;
      end
`ifdef SG_DMA_RD_ARB_PRIO_EN
      if (state == GNT && id != '0) ptr <= id_nx;
`else
      if (state == GNT) ptr <= id_nx;
`endif
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (beat && !empty) begin
        left         <= rem - 1'b1;
        ch_rd_data_o <= rd_master_data_i;
      end
      ch_rd_data_valid_o <= beat && !empty ? NUM_CH'(1) << f_id[rp[PW-1:0]] : '0;
      if (beat && empty) err_o <= 1'b1;
    end

  always_ff @(posedge clk)
    if (push) begin
      f_id[wp[PW-1:0]] <= id;
      f_bc[wp[PW-1:0]] <= rd_master_bcount_o;
    end
endmodule

// File: tb/tb_sg_dma_rd_arb.sv
// tb_sg_dma_rd_arb: directed vectors for arbitration order, issue handshake, outstanding limit and beat routing.
`timescale 1ns/1ps
module tb_sg_dma_rd_arb;
  logic clk = 1'b0, reset = 1'b0, wreq = 1'b0, dv = 1'b0;
  logic [3:0] req = '0;
  logic [127:0] addr = '0;
  logic [43:0] bc = '0;
  logic [255:0] dat = '0;
  logic [3:0] gnt, vld, outst;
  logic [255:0] rdata;
  logic [31:0] maddr;
  logic [10:0] mbc;
  logic mrd, err;
  int n = 0, errs = 0, ch, cyc;
`ifdef SG_DMA_RD_ARB_PRIO_EN
  int exp2 [6] = '{0, 0, 0, 0, 0, 0};
`else
  int exp2 [6] = '{0, 1, 2, 3, 0, 1};
`endif
  logic [3:0] exp5 [6] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0010};

  always #5 clk = ~clk;

  sg_dma_rd_arb dut (
    .clk(clk), .reset(reset),
    .ch_rd_req_i(req), .ch_rd_addr_i(addr), .ch_rd_bcount_i(bc),
    .ch_rd_gnt_o(gnt), .ch_rd_data_o(rdata), .ch_rd_data_valid_o(vld),
    .rd_master_addr_o(maddr), .rd_master_bcount_o(mbc), .rd_master_rd_o(mrd),
    .rd_master_wait_req_i(wreq), .rd_master_data_valid_i(dv), .rd_master_data_i(dat),
    .outst_cnt_o(outst), .err_o(err)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] a, input logic [10:0] b);
    req[k] = 1'b1;
    addr[k*32 +: 32] = a;
    bc[k*11 +: 11] = b;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    dv = 1'b0;
    wreq = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic wait_gnt(output int c, output int cy);
    c = -1;
    cy = 0;
    while (c < 0 && cy < 20) begin
      tick;
      cy++;
      for (int k = 0; k < 4; k++) if (gnt == 4'(1 << k)) c = k;
    end
    if (c < 0) begin
      n++;
      errs++;
      $error("FAIL gnt_timeout: observed no one-hot grant expected one within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    do_reset;
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", vld, 0);
    chk("rst_rd", mrd, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_bc", mbc, 0);
    chk("rst_outst", outst, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rdata, 0);
    // single ch1 burst of 4
    set_ch(1, 32'h1000, 11'd4);
    tick;
    chk("t1_rd", mrd, 1);
    chk("t1_addr", maddr, 'h1000);
    chk("t1_bc", mbc, 4);
    chk("t1_nognt", gnt, 0);
    tick;
    chk("t1_rd_off", mrd, 0);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_outst", outst, 1);
    req = '0;
    for (int k = 0; k < 4; k++) begin
      dv = 1'b1;
      dat = 256'(k + 'h11);
      tick;
      chk("t1_vld", vld, 4'b0010);
      chk("t1_data", rdata, k + 'h11);
    end
    dv = 1'b0;
    tick;
    chk("t1_vld_lo", vld, 0);
    chk("t1_hold", rdata, 'h14);
    chk("t1_outst0", outst, 0);
    // all channels requesting continuously
    do_reset;
    for (int k = 0; k < 4; k++) set_ch(k, 32'(k * 'h100), 11'd1);
    for (int g = 0; g < 6; g++) begin
      wait_gnt(ch, cyc);
      chk("t2_order", ch, exp2[g]);
      if (g > 0) chk("t2_spacing", cyc, 3);
    end
    req = '0;
    chk("t2_outst", outst, 6);
    for (int g = 0; g < 6; g++) begin
      dv = 1'b1;
      tick;
      chk("t2_route", vld, 4'b0001 << exp2[g]);
    end
    dv = 1'b0;
    tick;
    chk("t2_outst0", outst, 0);
    // waitrequest held during ISSUE
    do_reset;
    wreq = 1'b1;
    set_ch(2, 32'h2000, 11'd2);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("t3_rd", mrd, 1);
      chk("t3_addr", maddr, 'h2000);
      chk("t3_bc", mbc, 2);
      chk("t3_nognt", gnt, 0);
      if (k == 5) wreq = 1'b0;
    end
    tick;
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_rd_off", mrd, 0);
    req = '0;
    // outstanding limit
    do_reset;
    set_ch(0, 32'h4000, 11'd2);
    for (int g = 0; g < 8; g++) begin
      wait_gnt(ch, cyc);
      chk("t4_gnt", ch, 0);
    end
    chk("t4_outst", outst, 8);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t4_stall_rd", mrd, 0);
      chk("t4_stall_gnt", gnt, 0);
    end
    dv = 1'b1;
    tick;
    tick;
    dv = 1'b0;
    chk("t4_pop", outst, 7);
    chk("t4_rd_wait", mrd, 0);
    tick;
    chk("t4_resume", mrd, 1);
    tick;
    chk("t4_gnt9", gnt, 4'b0001);
    chk("t4_outst9", outst, 8);
    req = '0;
    // back-to-back bursts with a push on the pop cycle
    do_reset;
    set_ch(2, 32'h2200, 11'd2);
    set_ch(3, 32'h3300, 11'd3);
    wait_gnt(ch, cyc);
    chk("t5_first", ch, 2);
    req[2] = 1'b0;
    wait_gnt(ch, cyc);
    chk("t5_second", ch, 3);
    req[3] = 1'b0;
    wreq = 1'b1;
    set_ch(1, 32'h1100, 11'd1);
    chk("t5_outst2", outst, 2);
    tick;
    tick;
    chk("t5_issue", mrd, 1);
    for (int k = 0; k < 6; k++) begin
      dv = 1'b1;
      dat = 256'(k + 'hA0);
      if (k == 1) wreq = 1'b0;
      tick;
      chk("t5_route", vld, exp5[k]);
      chk("t5_data", rdata, k + 'hA0);
      if (k == 1) begin
        chk("t5_pushpop", outst, 2);
        chk("t5_gnt1", gnt, 4'b0010);
        req = '0;
      end
      if (k == 4) chk("t5_outst1", outst, 1);
    end
    dv = 1'b0;
    tick;
    chk("t5_vld_lo", vld, 0);
    chk("t5_outst0", outst, 0);
    // stray beat, then reset mid-burst
    do_reset;
    dv = 1'b1;
    tick;
    chk("t6_vld", vld, 0);
    chk("t6_err", err, 1);
    dv = 1'b0;
    tick;
    chk("t6_sticky", err, 1);
    set_ch(0, 32'h6000, 11'd4);
    wait_gnt(ch, cyc);
    req = '0;
    dv = 1'b1;
    dat = 256'h66;
    tick;
    dv = 1'b0;
    chk("t6_vld_mid", vld, 4'b0001);
    chk("t6_outst_mid", outst, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_r_gnt", gnt, 0);
    chk("t6_r_vld", vld, 0);
    chk("t6_r_rd", mrd, 0);
    chk("t6_r_addr", maddr, 0);
    chk("t6_r_bc", mbc, 0);
    chk("t6_r_outst", outst, 0);
    chk("t6_r_err", err, 0);
    chk("t6_r_data", rdata, 0);
    tick;
    reset = 1'b1;
    dv = 1'b1;
    tick;
    dv = 1'b0;
    chk("t6_late_err", err, 1);
    chk("t6_late_vld", vld, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
